// File: rtl/card_select_ctrl.sv
// rtl/card_select_ctrl.sv - button conditioning, 6x6 cursor and card select FSM
module card_select_ctrl #(
   parameter int GRID_W          = 6,
   parameter int GRID_H          = 6,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       btn_up,
   input  logic                       btn_down,
   input  logic                       btn_left,
   input  logic                       btn_right,
   input  logic                       btn_a,
   input  logic                       select_en,
   input  logic [GRID_W*GRID_H-1:0]   matched,
   input  logic                       result_done,
   output logic [5:0]                 mem6x6,
   output logic                       A,
   output logic                       card_sel,
   output logic                       reject,
   output logic                       busy
);

   localparam int NB    = 5;
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RW    = (GRID_H > 1) ? $clog2(GRID_H) : 1;
   localparam int CW    = (GRID_W > 1) ? $clog2(GRID_W) : 1;

   // button index: 0 up, 1 down, 2 left, 3 right, 4 select
   logic [NB-1:0]    raw;
   logic [NB-1:0]    sync1;
   logic [NB-1:0]    sync2;
   logic [NB-1:0]    level;
   logic [NB-1:0]    level_q;
   logic [NB-1:0]    press;
   logic [CNT_W-1:0] cnt [NB];

   typedef enum logic [1:0] {
      ST_FIRST  = 2'd0,
      ST_SECOND = 2'd1,
      ST_WAIT   = 2'd2
   } state_t;

   state_t           state;
   logic [5:0]       first_pos;
   logic [RW-1:0]    row;
   logic [CW-1:0]    col;
   logic [RW-1:0]    row_nx;
   logic [CW-1:0]    col_nx;
   logic [5:0]       pos_nx;
   logic             mv_up;
   logic             mv_down;
   logic             mv_left;
   logic             mv_right;
   logic             sel_go;

   assign raw = {btn_a, btn_right, btn_left, btn_down, btn_up};

   // synchronise, debounce and edge-detect every button; the press pulse is registered
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1   <= '0;
         sync2   <= '0;
         level   <= '0;
         level_q <= '0;
         press   <= '0;
         for (int i = 0; i < NB; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         sync1   <= raw;
         sync2   <= sync1;
         level_q <= level;
         press   <= level & ~level_q;
         for (int i = 0; i < NB; i++) begin
            if (sync2[i] != level[i]) begin
               if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                  level[i] <= sync2[i];
                  cnt[i]   <= '0;
               end else begin
                  cnt[i] <= cnt[i] + CNT_W'(1);
               end
            end else begin
               cnt[i] <= '0;
            end
         end
      end
   end

   // one direction per cycle (up > down > left > right), each axis wraps on itself
   always_comb begin
      mv_up    = press[0];
      mv_down  = press[1] & ~press[0];
      mv_left  = press[2] & ~press[1] & ~press[0];
      mv_right = press[3] & ~press[2] & ~press[1] & ~press[0];
      row_nx   = row;
      col_nx   = col;
      if (mv_up) begin
         row_nx = (row == '0) ? RW'(GRID_H - 1) : row - RW'(1);
      end else if (mv_down) begin
         row_nx = (row == RW'(GRID_H - 1)) ? '0 : row + RW'(1);
      end else if (mv_left) begin
         col_nx = (col == '0) ? CW'(GRID_W - 1) : col - CW'(1);
      end else if (mv_right) begin
         col_nx = (col == CW'(GRID_W - 1)) ? '0 : col + CW'(1);
      end
      pos_nx = 6'(int'(row_nx) * GRID_W + int'(col_nx));
      sel_go = select_en & press[4];
   end

   // cursor update and select FSM; select is judged on the pre-move position
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_FIRST;
         first_pos <= '0;
         row       <= '0;
         col       <= '0;
         mem6x6    <= '0;
         A         <= 1'b0;
         card_sel  <= 1'b0;
         reject    <= 1'b0;
         busy      <= 1'b0;
      end else begin
         A      <= 1'b0;
         reject <= 1'b0;
         if (select_en) begin
            row    <= row_nx;
            col    <= col_nx;
            mem6x6 <= pos_nx;
         end
         case (state)
            ST_FIRST: begin
               if (sel_go) begin
                  if (matched[mem6x6]) begin
                     reject <= 1'b1;
                  end else begin
                     A         <= 1'b1;
                     card_sel  <= 1'b0;
                     first_pos <= mem6x6;
                     state     <= ST_SECOND;
                  end
               end
            end
            ST_SECOND: begin
               if (sel_go) begin
                  if (matched[mem6x6] || (mem6x6 == first_pos)) begin
                     reject <= 1'b1;
                  end else begin
                     A        <= 1'b1;
                     card_sel <= 1'b1;
                     busy     <= 1'b1;
                     state    <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (sel_go) begin
                  reject <= 1'b1;
               end
               if (result_done) begin
                  busy  <= 1'b0;
                  state <= ST_FIRST;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= ST_FIRST;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_card_select_ctrl.sv
// tb/tb_card_select_ctrl.sv - randomized and directed bench for card_select_ctrl
module tb_card_select_ctrl;

   localparam int DEB = 16;
   localparam logic [4:0] K_UP = 5'b00001;
   localparam logic [4:0] K_DN = 5'b00010;
   localparam logic [4:0] K_LF = 5'b00100;
   localparam logic [4:0] K_RT = 5'b01000;
   localparam logic [4:0] K_A  = 5'b10000;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [4:0]  btn = '0;
   logic        select_en = 1'b0;
   logic [35:0] matched = '0;
   logic        result_done = 1'b0;
   logic [5:0]  mem6x6;
   logic        A;
   logic        card_sel;
   logic        reject;
   logic        busy;

   card_select_ctrl #(
      .GRID_W(6),
      .GRID_H(6),
      .DEBOUNCE_CYCLES(DEB)
   ) dut (
      .clock(clock),
      .reset_n(reset_n),
      .btn_up(btn[0]),
      .btn_down(btn[1]),
      .btn_left(btn[2]),
      .btn_right(btn[3]),
      .btn_a(btn[4]),
      .select_en(select_en),
      .matched(matched),
      .result_done(result_done),
      .mem6x6(mem6x6),
      .A(A),
      .card_sel(card_sel),
      .reject(reject),
      .busy(busy)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      if (obs != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // reference model: game rules in plain integers, debounce as "DEB agreeing samples"
   int       m_row = 0, m_col = 0, m_state = 0, m_first = 0;
   int       m_a = 0, m_rej = 0, m_sel = 0, m_busy = 0;
   bit [4:0] r1 = '0, r2 = '0, lvl = '0, pipe1 = '0, pipe2 = '0;
   int       streak [5] = '{0, 0, 0, 0, 0};

   int a_cnt = 0, rej_cnt = 0, last_a_pos = -1, last_a_sel = -1;

   always @(posedge clock) begin
      bit [4:0] eff;
      int       pos;
      int       st0;
      if (!reset_n) begin
         m_row = 0; m_col = 0; m_state = 0; m_first = 0;
         m_a = 0; m_rej = 0; m_sel = 0; m_busy = 0;
         r1 = '0; r2 = '0; lvl = '0; pipe1 = '0; pipe2 = '0;
         for (int b = 0; b < 5; b++) streak[b] = 0;
      end else begin
         eff   = pipe2;
         pipe2 = pipe1;
         pipe1 = '0;
         for (int b = 0; b < 5; b++) begin
            if (r2[b] != lvl[b]) begin
               streak[b]++;
               if (streak[b] == DEB) begin
                  lvl[b]    = r2[b];
                  streak[b] = 0;
                  if (r2[b]) pipe1[b] = 1'b1;
               end
            end else begin
               streak[b] = 0;
            end
         end
         r2 = r1;
         r1 = btn;
         m_a = 0;
         m_rej = 0;
         st0 = m_state;
         if (select_en) begin
            pos = m_row * 6 + m_col;
            if (eff[4]) begin
               if (m_state == 0) begin
                  if (matched[pos]) m_rej = 1;
                  else begin m_a = 1; m_sel = 0; m_first = pos; m_state = 1; end
               end else if (m_state == 1) begin
                  if (matched[pos] || pos == m_first) m_rej = 1;
                  else begin m_a = 1; m_sel = 1; m_state = 2; end
               end else begin
                  m_rej = 1;
               end
            end
            if (eff[0])      m_row = (m_row + 5) % 6;
            else if (eff[1]) m_row = (m_row + 1) % 6;
            else if (eff[2]) m_col = (m_col + 5) % 6;
            else if (eff[3]) m_col = (m_col + 1) % 6;
         end
         if (result_done && st0 == 2) m_state = 0;
         m_busy = (m_state == 2) ? 1 : 0;
      end
      #1;
      chk("mem6x6", mem6x6, m_row * 6 + m_col);
      chk("A", A, m_a);
      chk("card_sel", card_sel, m_sel);
      chk("reject", reject, m_rej);
      chk("busy", busy, m_busy);
      if (A) begin a_cnt++; last_a_pos = mem6x6; last_a_sel = card_sel; end
      if (reject) rej_cnt++;
   end

   task automatic move_chk(input logic [4:0] mask, input int prev, input int exp, input string tag);
      @(negedge clock);
      btn = mask;
      repeat (DEB + 3) @(posedge clock);
      #1 chk({tag, "_early"}, mem6x6, prev);
      @(posedge clock);
      #1 chk(tag, mem6x6, exp);
      @(negedge clock);
      btn = '0;
      repeat (DEB + 8) @(negedge clock);
   endtask

   task automatic tap(input logic [4:0] mask);
      @(negedge clock);
      btn = mask;
      repeat (DEB + 8) @(negedge clock);
      btn = '0;
      repeat (DEB + 8) @(negedge clock);
   endtask

   task automatic pulse_done();
      @(negedge clock);
      result_done = 1'b1;
      @(negedge clock);
      result_done = 1'b0;
   endtask

   initial begin
      int a0, r0, n;
      logic [4:0] mask;

      repeat (3) @(negedge clock);
      #1;
      chk("rst_mem", mem6x6, 0);
      chk("rst_a", A, 0);
      chk("rst_busy", busy, 0);
      @(negedge clock);
      reset_n = 1'b1;
      select_en = 1'b1;

      move_chk(K_RT, 0, 1, "r1");
      move_chk(K_RT, 1, 2, "r2");
      move_chk(K_RT, 2, 3, "r3");
      move_chk(K_DN, 3, 9, "d1");
      move_chk(K_DN, 9, 15, "d2");
      move_chk(K_UP, 15, 9, "u1");
      move_chk(K_UP, 9, 3, "u2");
      move_chk(K_RT, 3, 4, "r4");
      move_chk(K_RT, 4, 5, "r5");
      move_chk(K_RT, 5, 0, "wrap_col");
      move_chk(K_UP, 0, 30, "wrap_row");
      move_chk(K_DN, 30, 0, "wrap_down");

      // bouncy select button
      a0 = a_cnt;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (i % 3 == 0) btn[4] = ~btn[4];
      end
      @(negedge clock);
      btn[4] = 1'b1;
      repeat (DEB + 10) @(negedge clock);
      btn = '0;
      repeat (DEB + 8) @(negedge clock);
      chk("bounce_cnt", a_cnt - a0, 1);
      chk("bounce_pos", last_a_pos, 0);
      chk("bounce_sel", last_a_sel, 0);

      for (int i = 0; i < 5; i++) tap(K_RT);
      tap(K_A);
      chk("second_busy", busy, 1);
      pulse_done();
      chk("done_busy", busy, 0);

      a0 = a_cnt; r0 = rej_cnt;
      tap(K_A);
      chk("sel5_a", a_cnt - a0, 1);
      chk("sel5_pos", last_a_pos, 5);
      chk("sel5_sel", last_a_sel, 0);
      tap(K_A);
      chk("same_rej", rej_cnt - r0, 1);
      chk("same_noa", a_cnt - a0, 1);
      tap(K_RT);
      for (int i = 0; i < 3; i++) tap(K_DN);
      tap(K_A);
      chk("sel18_pos", last_a_pos, 18);
      chk("sel18_sel", last_a_sel, 1);
      chk("sel18_busy", busy, 1);
      pulse_done();

      matched[18] = 1'b1;
      a0 = a_cnt; r0 = rej_cnt;
      tap(K_A);
      chk("match_rej", rej_cnt - r0, 1);
      chk("match_noa", a_cnt - a0, 0);
      tap(K_RT);
      tap(K_A);
      tap(K_RT);
      tap(K_A);
      chk("pair_sel", last_a_sel, 1);
      chk("pair_busy", busy, 1);
      r0 = rej_cnt;
      tap(K_A);
      chk("wait_rej", rej_cnt - r0, 1);
      pulse_done();
      chk("wait_clear", busy, 0);
      tap(K_A);
      chk("next_sel", last_a_sel, 0);
      chk("next_pos", last_a_pos, 20);

      tap(K_LF);
      tap(K_LF);
      for (int i = 0; i < 3; i++) tap(K_UP);
      move_chk(K_UP | K_RT, 0, 30, "up_right");

      // reset in the middle of a select debounce
      a0 = a_cnt;
      @(negedge clock);
      btn = K_A;
      repeat (8) @(negedge clock);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_mem", mem6x6, 0);
      chk("mid_rst_sel", card_sel, 0);
      chk("mid_rst_busy", busy, 0);
      repeat (2) @(negedge clock);
      btn = '0;
      @(negedge clock);
      reset_n = 1'b1;
      repeat (DEB + 10) @(negedge clock);
      chk("mid_rst_noa", a_cnt - a0, 0);
      chk("mid_rst_pos", mem6x6, 0);
      matched = '0;

      // randomized phase, checked every cycle by the model
      for (int t = 0; t < 70; t++) begin
         @(negedge clock);
         select_en = ($urandom_range(0, 7) != 0);
         if (t % 10 == 0)
            matched = 36'({$urandom(), $urandom()}) & 36'({$urandom(), $urandom()})
                      & 36'({$urandom(), $urandom()});
         if ($urandom_range(0, 2) == 0) mask = K_A;
         else mask = 5'(1 << $urandom_range(0, 4));
         if ($urandom_range(0, 5) == 0) mask = mask | 5'(1 << $urandom_range(0, 4));
         if ($urandom_range(0, 3) == 0) begin
            n = $urandom_range(4, 20);
            for (int i = 0; i < n; i++) begin
               btn = $urandom_range(0, 1) ? mask : 5'b0;
               result_done = ($urandom_range(0, 15) == 0);
               @(negedge clock);
            end
         end
         btn = mask;
         n = $urandom_range(4, DEB + 12);
         for (int i = 0; i < n; i++) begin
            result_done = ($urandom_range(0, 15) == 0);
            @(negedge clock);
         end
         btn = '0;
         n = $urandom_range(DEB + 3, DEB + 12);
         for (int i = 0; i < n; i++) begin
            result_done = ($urandom_range(0, 15) == 0);
            @(negedge clock);
         end
      end
      result_done = 1'b0;
      repeat (5) @(negedge clock);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
